// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; registered one-cycle lookup.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update into the lookup result.
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  input  logic                  flush,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic                  load_en
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  logic                  valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_reg    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_reg [ENTRIES];
  logic [1:0]            ctr_reg    [ENTRIES];

  logic                  pred_valid_reg;
  logic                  pred_hit_reg;
  logic                  pred_taken_reg;
  logic [ADDR_WIDTH-1:0] pred_target_reg;

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] upd_index;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  unused_pc_bits;

  assign lookup_index   = lookup_pc[INDEX_BITS+1:2];
  assign lookup_tag     = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign upd_index      = upd_pc[INDEX_BITS+1:2];
  assign upd_tag        = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Post-update image of the entry addressed by upd_pc.
  logic                  upd_hit;
  logic                  upd_write;
  logic                  wr_valid;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [ADDR_WIDTH-1:0] wr_target;
  logic [1:0]            wr_ctr;

  always_comb begin
    upd_hit   = valid_reg[upd_index] && (tag_reg[upd_index] == upd_tag);
    upd_write = 1'b0;
    wr_valid  = valid_reg[upd_index];
    wr_tag    = tag_reg[upd_index];
    wr_target = target_reg[upd_index];
    wr_ctr    = ctr_reg[upd_index];
    if (upd_valid && !flush) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          wr_target = upd_target;
          if (wr_ctr != 2'd3) wr_ctr = wr_ctr + 2'd1;
        end else if (wr_ctr != 2'd0) begin
          wr_ctr = wr_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        upd_write = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = upd_tag;
        wr_target = upd_target;
        wr_ctr    = 2'd2;
      end
    end
  end

  logic [ENTRIES-1:0] entry_we;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_we
    assign entry_we[gi] = upd_write && (upd_index == INDEX_BITS'(gi));
  end

  // Flush only clears valid bits; allocation always rewrites the counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= 2'd0;
      end
    end else if (Tick) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          valid_reg[i] <= 1'b0;
        end else if (entry_we[i]) begin
          valid_reg[i]  <= wr_valid;
          tag_reg[i]    <= wr_tag;
          target_reg[i] <= wr_target;
          ctr_reg[i]    <= wr_ctr;
        end
      end
    end
  end

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [ADDR_WIDTH-1:0] rd_target;
  logic [1:0]            rd_ctr;
  logic                  look_hit;

  always_comb begin
    rd_valid  = valid_reg[lookup_index];
    rd_tag    = tag_reg[lookup_index];
    rd_target = target_reg[lookup_index];
    rd_ctr    = ctr_reg[lookup_index];
`ifdef BTB_BYPASS_EN
    if (upd_write && (upd_index == lookup_index)) begin
      rd_valid  = wr_valid;
      rd_tag    = wr_tag;
      rd_target = wr_target;
      rd_ctr    = wr_ctr;
    end
`endif
    // A flush in the lookup cycle forces a miss regardless of table contents.
    look_hit = rd_valid && (rd_tag == lookup_tag) && !flush;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pred_valid_reg  <= 1'b0;
      pred_hit_reg    <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_target_reg <= '0;
    end else if (Tick) begin
      pred_valid_reg  <= lookup_valid;
      pred_hit_reg    <= look_hit;
      pred_taken_reg  <= look_hit && rd_ctr[1];
      pred_target_reg <= look_hit ? rd_target : '0;
    end
  end

  assign pred_valid  = pred_valid_reg;
  assign pred_hit    = pred_hit_reg;
  assign pred_taken  = pred_taken_reg;
  assign pred_target = pred_target_reg;
  assign load_en     = pred_valid_reg && pred_taken_reg;

endmodule
